// File: rtl/_arb_mux_pkg.sv
// Shared constants and types for the arbitrating multiplexer.
package _arb_mux_pkg;

  localparam int unsigned WORD_LENGTH = 16;

  typedef enum logic {
    ARB_EMPTY = 1'b0,
    ARB_FULL  = 1'b1
  } arb_state_t;

endpackage

// File: rtl/_arb_mux_if.sv
// Producer/consumer handshake bundle for the arbitrating multiplexer.
interface _arb_mux_if #(
  parameter int unsigned n = _arb_mux_pkg::WORD_LENGTH,
  parameter int unsigned m = 16
);
  localparam int unsigned s = $clog2(m);

  logic [m-1:0]        in_valid;
  logic [m-1:0][n-1:0] in;
  logic [m-1:0]        in_ready;
  logic                out_valid;
  logic [n-1:0]        out;
  logic [s-1:0]        out_src;
  logic                out_ready;

  modport master (
    output in_valid, in, out_ready,
    input  in_ready, out_valid, out, out_src
  );

  modport slave (
    input  in_valid, in, out_ready,
    output in_ready, out_valid, out, out_src
  );

endinterface

// File: rtl/_arb_mux_rr_arbiter.sv
// Combinational round-robin arbiter: rotate requests by ptr, pick lowest set
// bit, rotate the index back. Driving ptr with 0 yields fixed lowest-index priority.
module _rr_arbiter #(
  parameter  int unsigned m = 16,
  localparam int unsigned s = $clog2(m)
) (
  input  logic [m-1:0] req,
  input  logic [s-1:0] ptr,
  output logic [m-1:0] gnt,
  output logic [s-1:0] idx,
  output logic         any
);

  localparam logic [s:0] m_w = (s+1)'(m);

  logic [m-1:0] rot;
  logic [s-1:0] pos;
  logic [s:0]   sum;

  assign rot = m'({req, req} >> ptr);

  // Lowest set bit of the rotated vector is the first requester at or after ptr.
  always_comb begin
    pos = '0;
    any = 1'b0;
    for (int i = int'(m) - 1; i >= 0; i--) begin
      if (rot[i]) begin
        pos = s'(i);
        any = 1'b1;
      end
    end
  end

  assign sum = {1'b0, pos} + {1'b0, ptr};
  assign idx = (sum >= m_w) ? s'(sum - m_w) : s'(sum);
  assign gnt = any ? (m'(1) << idx) : '0;

endmodule

// File: rtl/_arb_mux.sv
// m-input, n-bit arbitrating multiplexer with a single registered output stage.
// ARB_MUX_FIXED_PRIO_EN: when defined, lowest index always wins and ptr is removed.
module _arb_mux
  import _arb_mux_pkg::*;
#(
  parameter  int unsigned n = WORD_LENGTH,
  parameter  int unsigned m = 16,
  localparam int unsigned s = $clog2(m)
) (
  input logic       clk,
  input logic       rst,
  _arb_mux_if.slave bus
);

  arb_state_t   state;
  logic [n-1:0] data;
  logic [s-1:0] src;
  logic [s-1:0] ptr;

  logic [m-1:0] gnt_c;
  logic [s-1:0] idx_c;
  logic         any_c;
  logic         load_c;

  _rr_arbiter #(.m(m)) u_arb (
    .req (bus.in_valid),
    .ptr (ptr),
    .gnt (gnt_c),
    .idx (idx_c),
    .any (any_c)
  );

  // Load whenever the output slot is free or being drained this cycle.
  assign load_c       = ((state == ARB_EMPTY) || bus.out_ready) && any_c;
  assign bus.in_ready = load_c ? gnt_c : '0;

`ifdef ARB_MUX_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [s-1:0] ptr_next_c;

  assign ptr_next_c = (idx_c == s'(m - 1)) ? '0 : s'(idx_c + 1'b1);

  // Priority rotates only when a word is actually taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= '0;
    end else if (load_c) begin
      ptr <= ptr_next_c;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ARB_EMPTY;
      data  <= '0;
      src   <= '0;
    end else begin
      case (state)
        ARB_EMPTY: begin
          if (load_c) begin
            state <= ARB_FULL;
            data  <= bus.in[idx_c];
            src   <= idx_c;
          end
        end
        ARB_FULL: begin
          if (load_c) begin
            data <= bus.in[idx_c];
            src  <= idx_c;
          end else if (bus.out_ready) begin
            state <= ARB_EMPTY;
          end
        end
        default: state <= ARB_EMPTY;
      endcase
    end
  end

  assign bus.out_valid = (state == ARB_FULL);
  assign bus.out       = data;
  assign bus.out_src   = src;

endmodule
